fp16add_arb: RTL and testbench
==============================

FP16ADD_ARB -- requirements
Module: fp16add_arb

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the statistics counters (used only with FP16ADD_ARB_STATS_EN).
REQ-002 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_req0_vld  input  1  requester 0 has an operand pair.
REQ-005 o_req0_rdy  output  1  requester 0 pair accepted this cycle when high with i_req0_vld.
REQ-006 i_req0_a, i_req0_b  input  16 each  requester 0 fp16 operands.
REQ-007 i_req1_vld, o_req1_rdy, i_req1_a, i_req1_b  same directions, widths and meaning for requester 1.
REQ-008 o_rsp_vld  output  1  result register holds a valid sum.
REQ-009 i_rsp_rdy  input  1  consumer takes the result this cycle.
REQ-010 o_rsp_res  output  16  fp16 sum.
REQ-011 o_rsp_id  output  1  requester that issued the result.
REQ-012 o_cnt0, o_cnt1  output  CNT_WIDTH each  completed responses per requester (present only with FP16ADD_ARB_STATS_EN).

Function
REQ-013 SHALL contain exactly one fp16add instance, shared by both requesters, fed by the granted requester's operands.
REQ-014 States: EMPTY (o_rsp_vld=0) and FULL (o_rsp_vld=1).
- EMPTY to FULL on a grant.
- FULL to EMPTY on i_rsp_rdy with no grant.
- FULL stays FULL on i_rsp_rdy with a grant.
- FULL stays FULL, with result held, while i_rsp_rdy=0.
REQ-015 A grant is possible when the state is EMPTY, or when it is FULL and i_rsp_rdy=1 (same-cycle drain and refill, full throughput).
REQ-016 Grant selection is round-robin.
- Single valid requester is granted.
- With both valid, the requester not granted last wins.
- Last-grant pointer updates only on a grant.
REQ-017 o_reqN_rdy is high only for the granted requester and only when a grant is possible. The rdy signals are combinational from vld, state, i_rsp_rdy and the pointer, and never depend on operand values.
REQ-018 Latency is one cycle: pair accepted at edge t, so o_rsp_vld=1 with o_rsp_res and o_rsp_id valid after edge t.
REQ-019 o_rsp_res equals the fp16add result of the accepted a and b (DAZ/FTZ, round toward zero) bit-exactly.
REQ-020 o_rsp_res and o_rsp_id SHALL be stable while o_rsp_vld=1 and i_rsp_rdy=0.
REQ-021 With no requester valid and a drain, the block goes to EMPTY. o_rsp_res and o_rsp_id keep their last value.
REQ-022 A requester deasserting vld without handshake is legal. No grant results and the pointer is unchanged.

Reset
REQ-023 While i_rst_n=0, asynchronously:
- state=EMPTY, o_rsp_vld=0, o_rsp_res=16'h0000, o_rsp_id=0.
- Pointer set so requester 0 wins the first tie.
- o_cnt0=o_cnt1=0.
REQ-024 Reset during FULL discards the held result. o_reqN_rdy SHALL be 0 while i_rst_n=0.
REQ-025 First grant is possible in the first cycle after i_rst_n deasserts.

Configuration
REQ-026 Macro FP16ADD_ARB_STATS_EN.
- Defined: o_cnt0/o_cnt1 exist. The counter matching o_rsp_id increments on each o_rsp_vld and i_rsp_rdy handshake, wrapping at 2^CNT_WIDTH.
- Undefined: counter ports and logic are absent. All other behaviour is identical.

Verification
REQ-027 Req0 only, a=16'h3C00, b=16'h3C00, i_rsp_rdy=1: one cycle later o_rsp_vld=1, o_rsp_res=16'h4000, o_rsp_id=0.
REQ-028 Both valid every cycle after reset, i_rsp_rdy=1: grants alternate 0,1,0,1, and one result per cycle with matching o_rsp_id.
REQ-029 FULL with i_rsp_rdy=0 for 5 cycles and both requesters valid: both rdy=0, o_rsp_res held. On i_rsp_rdy=1, same-cycle refill occurs with no bubble.
REQ-030 Req1 a=16'h7C00, b=16'hFC00: o_rsp_res is a NaN (exponent 5'h1F, mantissa nonzero), o_rsp_id=1. Req0 a=16'h4000, b=16'hC000: o_rsp_res=16'h0000.
REQ-031 i_rst_n pulled low while FULL: o_rsp_vld=0 immediately (asynchronously). After release, a tie grants requester 0.
REQ-032 With FP16ADD_ARB_STATS_EN and CNT_WIDTH=2: 5 req0 handshakes give o_cnt0=1 (wrap) and o_cnt1=0.

Source files
------------

// File: rtl/fp16add_arb.sv
// fp16add_arb: two requesters share one fp16 adder through a round-robin
// arbiter feeding a single result register (one-cycle latency, full
// throughput). Optional per-requester response counters are built only
// when FP16ADD_ARB_STATS_EN is defined.

// fp16add: combinational fp16 adder. Denormal inputs are read as zero,
// tiny results flush to zero, and rounding is toward zero.
module fp16add (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic        a_nan, b_nan, a_inf, b_inf;
  logic [14:0] mag_a, mag_b;
  logic        swap, sx, sy;
  logic [4:0]  ex, ey;
  logic [10:0] sigx, sigy;
  logic [42:0] alx, aly;
  logic [43:0] wide, norm;
  logic [5:0]  lead;
  logic [7:0]  etmp;

  // Exact add on a 43-bit aligned grid, so truncating after normalisation
  // is a true round toward zero and needs no guard or sticky bits.
  always_comb begin
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != '0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != '0);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == '0);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == '0);
    mag_a = (a[14:10] == '0) ? '0 : a[14:0];
    mag_b = (b[14:10] == '0) ? '0 : b[14:0];
    swap  = mag_b > mag_a;
    sx    = swap ? b[15] : a[15];
    sy    = swap ? a[15] : b[15];
    ex    = swap ? mag_b[14:10] : mag_a[14:10];
    ey    = swap ? mag_a[14:10] : mag_b[14:10];
    sigx  = (ex == '0) ? '0 : {1'b1, (swap ? mag_b[9:0] : mag_a[9:0])};
    sigy  = (ey == '0) ? '0 : {1'b1, (swap ? mag_a[9:0] : mag_b[9:0])};
    alx   = {sigx, 32'b0};
    aly   = {sigy, 32'b0} >> (ex - ey);
    if (sx == sy) wide = {1'b0, alx} + {1'b0, aly};
    else          wide = {1'b0, alx} - {1'b0, aly};
    lead = '0;
    for (int unsigned i = 0; i < 44; i++) begin
      if (wide[i]) lead = 6'(i);
    end
    norm = wide << (6'd43 - lead);
    etmp = {3'b0, ex} + {2'b0, lead};
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) y = 16'h7E00;
    else if (a_inf)        y = a;
    else if (b_inf)        y = b;
    else if (wide == '0)   y = {a[15] & b[15], 15'b0};
    else if (etmp <= 8'd42) y = {sx, 15'b0};
    else if (etmp >= 8'd73) y = {sx, 15'h7BFF};
    else                   y = {sx, 5'(etmp - 8'd42), norm[42:33]};
  end

endmodule

module fp16add_arb #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req0_vld,
  output logic                 o_req0_rdy,
  input  logic [15:0]          i_req0_a,
  input  logic [15:0]          i_req0_b,
  input  logic                 i_req1_vld,
  output logic                 o_req1_rdy,
  input  logic [15:0]          i_req1_a,
  input  logic [15:0]          i_req1_b,
  output logic                 o_rsp_vld,
  input  logic                 i_rsp_rdy,
  output logic [15:0]          o_rsp_res,
  output logic                 o_rsp_id
`ifdef FP16ADD_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] o_cnt0,
  output logic [CNT_WIDTH-1:0] o_cnt1
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state, state_nxt;
  logic        last_id;
  logic        can_grant, gnt0, gnt1, grant;
  logic [15:0] op_a, op_b, sum;

  fp16add u_add (
    .a (op_a),
    .b (op_b),
    .y (sum)
  );

  // Round-robin grant, operand mux and next state; ready is held low in reset.
  always_comb begin
    state_nxt = state;
    can_grant = i_rst_n & ((state == EMPTY) | i_rsp_rdy);
    gnt0      = can_grant & i_req0_vld & (~i_req1_vld | last_id);
    gnt1      = can_grant & i_req1_vld & (~i_req0_vld | ~last_id);
    grant     = gnt0 | gnt1;
    op_a      = gnt1 ? i_req1_a : i_req0_a;
    op_b      = gnt1 ? i_req1_b : i_req0_b;
    if (grant)                             state_nxt = FULL;
    else if ((state == FULL) && i_rsp_rdy) state_nxt = EMPTY;
  end

  assign o_req0_rdy = gnt0;
  assign o_req1_rdy = gnt1;
  assign o_rsp_vld  = (state == FULL);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  // Result register and last-grant pointer load only on a grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_res <= '0;
      o_rsp_id  <= 1'b0;
      last_id   <= 1'b1;
    end else if (grant) begin
      o_rsp_res <= sum;
      o_rsp_id  <= gnt1;
      last_id   <= gnt1;
    end
  end

`ifdef FP16ADD_ARB_STATS_EN
  // Count consumed responses per issuing requester, wrapping naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt0 <= '0;
      o_cnt1 <= '0;
    end else if (o_rsp_vld && i_rsp_rdy) begin
      if (o_rsp_id) o_cnt1 <= o_cnt1 + CNT_WIDTH'(1);
      else          o_cnt0 <= o_cnt0 + CNT_WIDTH'(1);
    end
  end
`else
  // CNT_WIDTH only sizes the counters; this empty block keeps it referenced.
  if (CNT_WIDTH == 0) begin : g_no_cnt
  end
`endif

endmodule

// File: tb/tb_fp16add_arb.sv
// Directed bench for fp16add_arb; define FP16ADD_ARB_STATS_EN to also
// exercise the response counters (built with CNT_WIDTH=2).
module tb_fp16add_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_vld, req0_rdy, req1_vld, req1_rdy;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_vld, rsp_rdy, rsp_id;
  logic [15:0] rsp_res;
`ifdef FP16ADD_ARB_STATS_EN
  logic [1:0]  cnt0, cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  // a, b, expected sum (all via requester 0)
  logic [47:0] vec [8] = '{
    {16'h3C00, 16'h0001, 16'h3C00},
    {16'h3C00, 16'h1400, 16'h3C01},
    {16'h3C00, 16'h1000, 16'h3C00},
    {16'h3C00, 16'h8C00, 16'h3BFF},
    {16'h3C00, 16'h9000, 16'h3BFF},
    {16'h7BFF, 16'h7BFF, 16'h7BFF},
    {16'hC000, 16'hBC00, 16'hC200},
    {16'h0401, 16'h8400, 16'h0000}
  };

  fp16add_arb #(.CNT_WIDTH(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req0_vld (req0_vld),
    .o_req0_rdy (req0_rdy),
    .i_req0_a   (req0_a),
    .i_req0_b   (req0_b),
    .i_req1_vld (req1_vld),
    .o_req1_rdy (req1_rdy),
    .i_req1_a   (req1_a),
    .i_req1_b   (req1_b),
    .o_rsp_vld  (rsp_vld),
    .i_rsp_rdy  (rsp_rdy),
    .o_rsp_res  (rsp_res),
    .o_rsp_id   (rsp_id)
`ifdef FP16ADD_ARB_STATS_EN
    ,
    .o_cnt0     (cnt0),
    .o_cnt1     (cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rsp_rdy = 1'b1;
    req0_vld = 1'b1; req1_vld = 1'b1;
    req0_a = 16'h3C00; req0_b = 16'h3C00; req1_a = 16'h4000; req1_b = 16'h4000;
    #12;
    check("rst_vld", rsp_vld, 0);
    check("rst_res", rsp_res, 16'h0000);
    check("rst_id", rsp_id, 0);
    check("rst_rdy0", req0_rdy, 0);
    check("rst_rdy1", req1_rdy, 0);
    req0_vld = 1'b0; req1_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 1.0 + 1.0 from requester 0, granted in the first cycle out of reset
    req0_vld = 1'b1; req0_a = 16'h3C00; req0_b = 16'h3C00;
    #1;
    check("first_rdy0", req0_rdy, 1);
    check("first_rdy1", req1_rdy, 0);
    tick();
    req0_vld = 1'b0;
    check("one_vld", rsp_vld, 1);
    check("one_res", rsp_res, 16'h4000);
    check("one_id", rsp_id, 0);

    // inf + -inf from requester 1
    req1_vld = 1'b1; req1_a = 16'h7C00; req1_b = 16'hFC00;
    #1;
    check("nan_rdy1", req1_rdy, 1);
    tick();
    req1_vld = 1'b0;
    check("nan_exp", rsp_res[14:10], 5'h1F);
    check("nan_man_nz", rsp_res[9:0] != 10'h0, 1);
    check("nan_id", rsp_id, 1);

    // 2.0 + -2.0 from requester 0
    req0_vld = 1'b1; req0_a = 16'h4000; req0_b = 16'hC000;
    tick();
    req0_vld = 1'b0;
    check("cancel_res", rsp_res, 16'h0000);
    check("cancel_id", rsp_id, 0);

    // back-to-back arithmetic vectors through requester 0
    foreach (vec[i]) begin
      req0_vld = 1'b1; req0_a = vec[i][47:32]; req0_b = vec[i][31:16];
      #1;
      check("vec_rdy0", req0_rdy, 1);
      tick();
      check("vec_vld", rsp_vld, 1);
      check("vec_res", rsp_res, vec[i][15:0]);
    end
    req0_vld = 1'b0;

    // 1.0 + 0.5 from requester 1, then drain with nobody valid
    req1_vld = 1'b1; req1_a = 16'h3C00; req1_b = 16'h3800;
    tick();
    req1_vld = 1'b0;
    check("r1_res", rsp_res, 16'h3E00);
    check("r1_id", rsp_id, 1);
    tick();
    check("drain_vld", rsp_vld, 0);
    check("drain_res", rsp_res, 16'h3E00);
    check("drain_id", rsp_id, 1);

    // fill, then assert reset while FULL
    req0_vld = 1'b1; req0_a = 16'h3C00; req0_b = 16'h3C00;
    req1_vld = 1'b1; req1_a = 16'h4000; req1_b = 16'h4000;
    rsp_rdy = 1'b0;
    tick();
    check("fill_vld", rsp_vld, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vld", rsp_vld, 0);
    check("arst_res", rsp_res, 16'h0000);
    check("arst_rdy0", req0_rdy, 0);
    check("arst_rdy1", req1_rdy, 0);
    @(negedge clk);
    rst_n = 1'b1; rsp_rdy = 1'b1;
    #1;
    check("tie_rdy0", req0_rdy, 1);
    check("tie_rdy1", req1_rdy, 0);

    // both valid every cycle: grants alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_rdy0", req0_rdy, (k % 2 == 0) ? 1 : 0);
      check("rr_rdy1", req1_rdy, (k % 2 == 0) ? 0 : 1);
      tick();
      check("rr_vld", rsp_vld, 1);
      check("rr_id", rsp_id, (k % 2 == 0) ? 0 : 1);
      check("rr_res", rsp_res, (k % 2 == 0) ? 16'h4000 : 16'h4400);
    end

    // consumer stalls 5 cycles with both requesters still valid
    rsp_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_rdy0", req0_rdy, 0);
      check("stall_rdy1", req1_rdy, 0);
      tick();
      check("stall_vld", rsp_vld, 1);
      check("stall_res", rsp_res, 16'h4400);
      check("stall_id", rsp_id, 1);
    end
    rsp_rdy = 1'b1;
    #1;
    check("refill_rdy0", req0_rdy, 1);
    check("refill_rdy1", req1_rdy, 0);
    tick();
    check("refill_vld", rsp_vld, 1);
    check("refill_res", rsp_res, 16'h4000);
    check("refill_id", rsp_id, 0);
    req0_vld = 1'b0; req1_vld = 1'b0;
    tick();
    check("end_vld", rsp_vld, 0);

`ifdef FP16ADD_ARB_STATS_EN
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    check("cnt_rst0", cnt0, 0);
    req0_vld = 1'b1; req0_a = 16'h3C00; req0_b = 16'h3C00;
    for (int k = 0; k < 5; k++) tick();
    req0_vld = 1'b0;
    tick();
    check("cnt0_wrap", cnt0, 1);
    check("cnt1_zero", cnt1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
